i2c_bit_sequencer: RTL and testbench

Bit- and phase-level sequencer for the I2C slave. It counts SCL edges after a START and tells the main controller when each byte and each ACK phase begins and ends. It emits single-cycle strobes for the RX shift register, the TX shift register and the controller: `rx_sample`, `tx_shift`, `byte_received`, `ack_prep`, `ack_check` and `ack_done`. It sits between the SCL/SDA edge and START/STOP detectors and the main controller FSM, and it also provides a bus-idle timeout.

---
 rtl/i2c_bit_sequencer.sv | 140 ++++++++++++++
 tb/tb_i2c_bit_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bit_sequencer.sv
// I2C slave bit/phase sequencer: counts SCL edges after START and emits
// single-cycle strobes for the RX/TX shifters and the ACK phase, plus a
// bus-inactivity abort.
module i2c_bit_sequencer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start,
  input  logic       stop,
  input  logic       rising_edge,
  input  logic       falling_edge,
  output logic       rx_sample,
  output logic       tx_shift,
  output logic       byte_received,
  output logic       ack_prep,
  output logic       ack_check,
  output logic       ack_done,
  output logic [3:0] bit_count,
  output logic       timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_WAIT_ACK_FALL,
    S_ACK_BIT,
    S_ACK_END
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] idle_cnt, idle_cnt_d;
  logic [3:0]    bit_count_d;
  logic          rx_d, tx_d, br_d, prep_d, check_d, done_d, tmo_d;
  logic          tmo_hit, fall_only;

  // A simultaneous rise+fall is a detector fault; only the rise counts.
  assign fall_only = falling_edge & ~rising_edge;
  assign tmo_hit   = (state != S_IDLE) && (idle_cnt == TMO_LAST);

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: stop > start > timeout > rising > falling
  always_comb begin
    state_nxt = state;
    if (stop)         state_nxt = S_IDLE;
    else if (start)   state_nxt = S_DATA;
    else if (tmo_hit) state_nxt = S_IDLE;
    else begin
      case (state)
        S_DATA:          if (rising_edge && bit_count == 4'd7) state_nxt = S_WAIT_ACK_FALL;
        S_WAIT_ACK_FALL: if (fall_only)   state_nxt = S_ACK_BIT;
        S_ACK_BIT:       if (rising_edge) state_nxt = S_ACK_END;
        S_ACK_END:       if (fall_only)   state_nxt = S_DATA;
        default:         state_nxt = S_IDLE;
      endcase
    end
  end

  // Output/next-value decode; results are registered below
  always_comb begin
    rx_d        = 1'b0;
    tx_d        = 1'b0;
    br_d        = 1'b0;
    prep_d      = 1'b0;
    check_d     = 1'b0;
    done_d      = 1'b0;
    tmo_d       = 1'b0;
    bit_count_d = bit_count;
    if (stop || start) begin
      bit_count_d = 4'd0;
    end else if (tmo_hit) begin
      tmo_d       = 1'b1;
      bit_count_d = 4'd0;
    end else begin
      case (state)
        S_DATA: begin
          if (rising_edge) begin
            rx_d        = 1'b1;
            bit_count_d = bit_count + 4'd1;
            br_d        = (bit_count == 4'd7);
          end else if (falling_edge && bit_count != 4'd0) begin
            // bit 7 is preloaded by the controller, so no shift on the first fall
            tx_d = 1'b1;
          end
        end
        S_WAIT_ACK_FALL: prep_d  = fall_only;
        S_ACK_BIT:       check_d = rising_edge;
        S_ACK_END: begin
          if (fall_only) begin
            done_d      = 1'b1;
            bit_count_d = 4'd0;
          end
        end
        default: bit_count_d = 4'd0;
      endcase
    end

    // Inactivity counter: any bus activity or idling clears it, else saturating count
    if (stop || start || rising_edge || falling_edge || state == S_IDLE || tmo_hit)
      idle_cnt_d = '0;
    else if (idle_cnt != '1)
      idle_cnt_d = idle_cnt + 1'b1;
    else
      idle_cnt_d = idle_cnt;
  end

  // Registered outputs and inactivity counter
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_sample     <= 1'b0;
      tx_shift      <= 1'b0;
      byte_received <= 1'b0;
      ack_prep      <= 1'b0;
      ack_check     <= 1'b0;
      ack_done      <= 1'b0;
      timeout       <= 1'b0;
      bit_count     <= 4'd0;
      idle_cnt      <= '0;
    end else begin
      rx_sample     <= rx_d;
      tx_shift      <= tx_d;
      byte_received <= br_d;
      ack_prep      <= prep_d;
      ack_check     <= check_d;
      ack_done      <= done_d;
      timeout       <= tmo_d;
      bit_count     <= bit_count_d;
      idle_cnt      <= idle_cnt_d;
    end
  end

endmodule

// File: tb/tb_i2c_bit_sequencer.sv
// Bench for i2c_bit_sequencer: directed scenarios plus random pulses, all
// checked each cycle against a frame-position model of the I2C byte/ACK cycle.
module tb_i2c_bit_sequencer;
  localparam int T = 16;

  logic clk = 1'b0;
  logic n_rst, start, stop, rising_edge, falling_edge;
  logic rx_sample, tx_shift, byte_received, ack_prep, ack_check, ack_done, timeout;
  logic [3:0] bit_count;

  i2c_bit_sequencer #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .stop(stop),
    .rising_edge(rising_edge), .falling_edge(falling_edge),
    .rx_sample(rx_sample), .tx_shift(tx_shift), .byte_received(byte_received),
    .ack_prep(ack_prep), .ack_check(ack_check), .ack_done(ack_done),
    .bit_count(bit_count), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a bus transaction is "active" after START; a byte is bits 0..8
  // received, then the ACK bit is tracked by how many of its three edges
  // (fall, rise, fall) have gone by.
  bit m_active;
  int m_bits, m_ack, m_quiet;
  bit e_rx, e_tx, e_br, e_ap, e_ac, e_ad, e_to;
  int cyc_n = 0, t_edge = 0, t_tmo = -1;
  int n_rx = 0, n_tx = 0, n_br = 0, n_ap = 0, n_ac = 0, n_ad = 0, n_to = 0;

  // Per-cycle model step and compare
  always @(posedge clk) begin
    {e_rx, e_tx, e_br, e_ap, e_ac, e_ad, e_to} = '0;
    cyc_n++;
    if (!n_rst) begin
      m_active = 0; m_bits = 0; m_ack = 0; m_quiet = 0;
    end else begin
      if (rising_edge || falling_edge) t_edge = cyc_n;
      if (stop) begin
        m_active = 0; m_bits = 0; m_ack = 0; m_quiet = 0;
      end else if (start) begin
        m_active = 1; m_bits = 0; m_ack = 0; m_quiet = 0;
      end else if (m_active && m_quiet == T - 1) begin
        e_to = 1; m_active = 0; m_bits = 0; m_ack = 0; m_quiet = 0;
      end else if (m_active) begin
        if (rising_edge) begin
          if (m_bits < 8) begin
            e_rx = 1; m_bits++; e_br = (m_bits == 8);
          end else if (m_ack == 1) begin
            e_ac = 1; m_ack = 2;
          end
        end else if (falling_edge) begin
          if (m_bits < 8) e_tx = (m_bits > 0);
          else if (m_ack == 0) begin e_ap = 1; m_ack = 1; end
          else if (m_ack == 2) begin e_ad = 1; m_ack = 0; m_bits = 0; end
        end
        m_quiet = (rising_edge || falling_edge) ? 0 : m_quiet + 1;
      end
    end
    #1;
    chk("rx_sample", rx_sample, e_rx);
    chk("tx_shift", tx_shift, e_tx);
    chk("byte_received", byte_received, e_br);
    chk("ack_prep", ack_prep, e_ap);
    chk("ack_check", ack_check, e_ac);
    chk("ack_done", ack_done, e_ad);
    chk("timeout", timeout, e_to);
    chk("bit_count", bit_count, m_bits);
    n_rx += rx_sample; n_tx += tx_shift; n_br += byte_received;
    n_ap += ack_prep;  n_ac += ack_check; n_ad += ack_done; n_to += timeout;
    if (timeout) t_tmo = cyc_n;
  end

  // One-cycle pulse of the given inputs; called at a negedge
  task automatic pulse(input logic s, input logic p, input logic r, input logic f);
    start = s; stop = p; rising_edge = r; falling_edge = f;
    @(negedge clk);
    start = 0; stop = 0; rising_edge = 0; falling_edge = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_pair(input int gap);
    pulse(0, 0, 1, 0); idle(gap);
    pulse(0, 0, 0, 1); idle(gap);
  endtask

  int b_rx, b_tx, b_br, b_ap, b_ac, b_ad;
  task automatic snap();
    b_rx = n_rx; b_tx = n_tx; b_br = n_br; b_ap = n_ap; b_ac = n_ac; b_ad = n_ad;
  endtask

  initial begin
    n_rst = 0; start = 0; stop = 0; rising_edge = 0; falling_edge = 0;
    idle(3);
    chk("reset_bit_count", bit_count, 0);
    chk("reset_strobes", {rx_sample, tx_shift, byte_received, ack_prep, ack_check, ack_done, timeout}, 0);
    n_rst = 1;
    idle(2);

    // Plain byte: 8 rises, 7 data falls (the 8th fall is the ACK start)
    snap();
    pulse(1, 0, 0, 0); idle(4);
    for (int i = 0; i < 7; i++) bit_pair(4);
    pulse(0, 0, 1, 0); idle(4);
    chk("byte_rx_count", n_rx - b_rx, 8);
    chk("byte_tx_count", n_tx - b_tx, 7);
    chk("byte_br_count", n_br - b_br, 1);
    chk("byte_bit_count", bit_count, 8);

    // ACK phase: fall, rise, fall
    pulse(0, 0, 0, 1); idle(4);
    pulse(0, 0, 1, 0); idle(4);
    pulse(0, 0, 0, 1); idle(4);
    chk("ack_prep_count", n_ap - b_ap, 1);
    chk("ack_check_count", n_ac - b_ac, 1);
    chk("ack_done_count", n_ad - b_ad, 1);
    chk("ack_bit_count", bit_count, 0);
    // Back in DATA: next rise samples
    snap();
    pulse(0, 0, 1, 0); idle(2);
    chk("after_ack_rx", n_rx - b_rx, 1);

    // Repeated START after 5 bits, then a full byte of back-to-back rises
    for (int i = 0; i < 4; i++) bit_pair(2);
    pulse(1, 0, 0, 0); idle(1);
    chk("rstart_bit_count", bit_count, 0);
    snap();
    for (int i = 0; i < 8; i++) pulse(0, 0, 1, 0);
    idle(1);
    chk("rstart_br", n_br - b_br, 1);
    chk("rstart_rx", n_rx - b_rx, 8);

    // STOP in ACK_BIT, then edges are ignored
    pulse(0, 0, 0, 1); idle(2);
    pulse(0, 1, 0, 0);
    snap();
    for (int i = 0; i < 3; i++) bit_pair(2);
    chk("stop_bit_count", bit_count, 0);
    chk("stop_no_rx", n_rx - b_rx, 0);
    chk("stop_no_ack", n_ac - b_ac, 0);

    // Timeout: 3 bits then silence
    pulse(1, 0, 0, 0); idle(2);
    for (int i = 0; i < 3; i++) bit_pair(3);
    t_tmo = -1;
    idle(25);
    chk("timeout_latency", t_tmo - t_edge, 16);
    chk("timeout_bit_count", bit_count, 0);
    snap();
    pulse(0, 0, 1, 0); idle(2);
    chk("timeout_then_idle", n_rx - b_rx, 0);

    // start and stop together: stop wins
    pulse(1, 1, 0, 0); idle(2);
    snap();
    pulse(0, 0, 1, 0); idle(2);
    chk("start_stop_idle", n_rx - b_rx, 0);

    // Simultaneous edges in DATA: only the rise
    pulse(1, 0, 0, 0); idle(2);
    pulse(0, 0, 1, 0); idle(2);
    snap();
    pulse(0, 0, 1, 1); idle(2);
    chk("collide_rx", n_rx - b_rx, 1);
    chk("collide_tx", n_tx - b_tx, 0);

    // Asynchronous reset mid-byte
    pulse(0, 0, 1, 0);
    #3 n_rst = 0;
    #1;
    chk("async_rst_bit_count", bit_count, 0);
    chk("async_rst_rx", rx_sample, 0);
    idle(2);
    n_rst = 1;
    snap();
    pulse(0, 0, 1, 0); idle(2);
    chk("post_rst_idle", n_rx - b_rx, 0);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 999) == 0) begin
        n_rst = 0; idle(2); n_rst = 1;
      end else if ($urandom_range(0, 199) == 0) begin
        idle(20);
      end else begin
        pulse($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 1,
              $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 25);
      end
    end
    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
